// File: rtl/prof_snapshot_reader.sv
// Snapshot-and-read window over six 64-bit cache-profiler counters.
// Define PROF_DELTA_MODE_EN to store per-capture deltas against a running baseline.
module prof_snapshot_reader #(
  parameter int CNT_BITS = 64,
  parameter int XLEN     = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CNT_BITS-1:0] iflush_cnt_i,
  input  logic [CNT_BITS-1:0] iflush_ltc_i,
  input  logic [CNT_BITS-1:0] dflush_rd_cnt_i,
  input  logic [CNT_BITS-1:0] dflush_rd_ltc_i,
  input  logic [CNT_BITS-1:0] dflush_wb_cnt_i,
  input  logic [CNT_BITS-1:0] dflush_wb_ltc_i,
  input  logic                snap_i,
  output logic                busy_o,
  input  logic                rd_valid_i,
  input  logic [3:0]          rd_addr_i,
  output logic                rd_ready_o,
  output logic [XLEN-1:0]     rd_data_o,
  output logic                rd_data_valid_o,
  output logic                rd_err_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_READY   = 2'd2
  } state_t;

`ifdef PROF_DELTA_MODE_EN
  localparam logic DELTA_EN = 1'b1;
`else
  localparam logic DELTA_EN = 1'b0;
`endif

  state_t              state_r;
  state_t              state_next_s;
  logic                capture_s;
  logic                accept_s;
  logic                held_s;
  logic [CNT_BITS-1:0] cnt_s   [0:5];
  logic [CNT_BITS-1:0] snap_r  [0:5];
  logic [31:0]         snap_id_r;
  logic [XLEN-1:0]     rd_word_s;
  logic                rd_word_err_s;
  logic [XLEN-1:0]     rd_data_r;
  logic                rd_err_r;
  logic                rd_vld_r;

  assign cnt_s[0] = iflush_cnt_i;
  assign cnt_s[1] = iflush_ltc_i;
  assign cnt_s[2] = dflush_rd_cnt_i;
  assign cnt_s[3] = dflush_rd_ltc_i;
  assign cnt_s[4] = dflush_wb_cnt_i;
  assign cnt_s[5] = dflush_wb_ltc_i;

  assign busy_o          = (state_r == S_CAPTURE);
  assign rd_ready_o      = (state_r != S_CAPTURE);
  assign held_s          = (state_r == S_READY);
  assign accept_s        = rd_valid_i & rd_ready_o;
  assign rd_data_o       = rd_data_r;
  assign rd_err_o        = rd_err_r;
  assign rd_data_valid_o = rd_vld_r;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state; a snap request while capturing is dropped
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (snap_i) state_next_s = S_CAPTURE;
        else        state_next_s = S_IDLE;
      end
      S_CAPTURE: begin
        capture_s    = 1'b1;
        state_next_s = S_READY;
      end
      S_READY: begin
        if (snap_i) state_next_s = S_CAPTURE;
        else        state_next_s = S_READY;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

`ifdef PROF_DELTA_MODE_EN
  logic [CNT_BITS-1:0] base_r [0:5];

  // Delta capture: store distance from the previous capture, then rebase
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < 6; k++) begin
        snap_r[k] <= '0;
        base_r[k] <= '0;
      end
    end else if (capture_s) begin
      for (int k = 0; k < 6; k++) begin
        snap_r[k] <= cnt_s[k] - base_r[k];
        base_r[k] <= cnt_s[k];
      end
    end else begin
      for (int k = 0; k < 6; k++) begin
        snap_r[k] <= snap_r[k];
        base_r[k] <= base_r[k];
      end
    end
  end
`else
  // Raw capture of all six counters in the same cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < 6; k++) snap_r[k] <= '0;
    end else if (capture_s) begin
      for (int k = 0; k < 6; k++) snap_r[k] <= cnt_s[k];
    end else begin
      for (int k = 0; k < 6; k++) snap_r[k] <= snap_r[k];
    end
  end
`endif

  // Capture sequence number, wraps at 2^32
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      snap_id_r <= 32'd0;
    end else if (capture_s) begin
      snap_id_r <= snap_id_r + 32'd1;
    end else begin
      snap_id_r <= snap_id_r;
    end
  end

  // Word map; counter words read as zero until a snapshot exists
  always_comb begin
    rd_word_s     = '0;
    rd_word_err_s = 1'b0;
    case (rd_addr_i)
      4'd12: rd_word_s = snap_id_r;
      4'd13: rd_word_s = {{(XLEN-2){1'b0}}, DELTA_EN, held_s};
      4'd14, 4'd15: rd_word_err_s = 1'b1;
      default: begin
        if (!held_s)          rd_word_s = '0;
        else if (rd_addr_i[0]) rd_word_s = snap_r[rd_addr_i[3:1]][XLEN +: XLEN];
        else                  rd_word_s = snap_r[rd_addr_i[3:1]][0 +: XLEN];
      end
    endcase
  end

  // Registered read response, zeroed whenever not valid
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_vld_r  <= 1'b0;
      rd_data_r <= '0;
      rd_err_r  <= 1'b0;
    end else if (accept_s) begin
      rd_vld_r  <= 1'b1;
      rd_data_r <= rd_word_s;
      rd_err_r  <= rd_word_err_s;
    end else begin
      rd_vld_r  <= 1'b0;
      rd_data_r <= '0;
      rd_err_r  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prof_snapshot_reader.sv
// Bench for prof_snapshot_reader: vector table, corner sequences and a randomized
// run against a snapshot model. Honours PROF_DELTA_MODE_EN like the design.
module tb_prof_snapshot_reader;

`ifdef PROF_DELTA_MODE_EN
  localparam bit DELTA = 1'b1;
`else
  localparam bit DELTA = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [63:0] cnt [0:5];
  logic        snap_i = 1'b0;
  logic        busy_o;
  logic        rd_valid_i = 1'b0;
  logic [3:0]  rd_addr_i = 4'd0;
  logic        rd_ready_o;
  logic [31:0] rd_data_o;
  logic        rd_data_valid_o;
  logic        rd_err_o;

  int total = 0;
  int bad   = 0;

  prof_snapshot_reader #(.CNT_BITS(64), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .iflush_cnt_i(cnt[0]), .iflush_ltc_i(cnt[1]),
    .dflush_rd_cnt_i(cnt[2]), .dflush_rd_ltc_i(cnt[3]),
    .dflush_wb_cnt_i(cnt[4]), .dflush_wb_ltc_i(cnt[5]),
    .snap_i(snap_i), .busy_o(busy_o),
    .rd_valid_i(rd_valid_i), .rd_addr_i(rd_addr_i), .rd_ready_o(rd_ready_o),
    .rd_data_o(rd_data_o), .rd_data_valid_o(rd_data_valid_o), .rd_err_o(rd_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          snap;
    bit          rv;
    logic [3:0]  addr;
    logic [63:0] c0;
    bit          e_valid;
    logic [31:0] e_data;
    bit          e_err;
    bit          e_busy;
  } vec_t;

  vec_t vecs [16];

  // Reference model: what a snapshot window holds, independent of any state encoding
  bit          m_cap;
  bit          m_held;
  logic [31:0] m_id;
  logic [63:0] m_snap [0:5];
  logic [63:0] m_base [0:5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    m_cap = 1'b0; m_held = 1'b0; m_id = 32'd0;
    for (int k = 0; k < 6; k++) begin
      m_snap[k] = 64'd0;
      m_base[k] = 64'd0;
    end
  endtask

  task automatic do_reset();
    snap_i = 1'b0; rd_valid_i = 1'b0; rd_addr_i = 4'd0;
    rst_i = 1'b0;
    #1;
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_valid", {63'd0, rd_data_valid_o}, 64'd0);
    chk("rst_data", {32'd0, rd_data_o}, 64'd0);
    chk("rst_err", {63'd0, rd_err_o}, 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    model_reset();
    chk("rst_ready", {63'd0, rd_ready_o}, 64'd1);
  endtask

  function automatic vec_t mk(bit s, bit rv, logic [3:0] a, logic [63:0] c0,
                              bit ev, logic [31:0] ed, bit ee, bit eb);
    vec_t v;
    v.snap = s; v.rv = rv; v.addr = a; v.c0 = c0;
    v.e_valid = ev; v.e_data = ed; v.e_err = ee; v.e_busy = eb;
    return v;
  endfunction

  function automatic void m_word(input logic [3:0] a, output logic [31:0] d, output bit e);
    logic [63:0] w;
    d = 32'd0;
    e = 1'b0;
    if (a < 4'd12) begin
      w = m_snap[a / 4'd2];
      if (m_held) d = a[0] ? w[63:32] : w[31:0];
    end else if (a == 4'd12) begin
      d = m_id;
    end else if (a == 4'd13) begin
      d = {30'd0, DELTA, m_held};
    end else begin
      e = 1'b1;
    end
  endfunction

  task automatic rand_cycle();
    logic [31:0] e_data;
    bit          e_err;
    bit          e_valid;
    snap_i     = ($urandom_range(0, 3) == 0);
    rd_valid_i = $urandom_range(0, 1);
    rd_addr_i  = 4'($urandom_range(0, 15));
    for (int k = 0; k < 6; k++) cnt[k] = {$urandom, $urandom};
    e_valid = rd_valid_i && !m_cap;
    e_data  = 32'd0;
    e_err   = 1'b0;
    if (e_valid) m_word(rd_addr_i, e_data, e_err);
    if (m_cap) begin
      for (int k = 0; k < 6; k++) begin
        m_snap[k] = DELTA ? (cnt[k] - m_base[k]) : cnt[k];
        m_base[k] = cnt[k];
      end
      m_id   = m_id + 32'd1;
      m_held = 1'b1;
      m_cap  = 1'b0;
    end else if (snap_i) begin
      m_cap = 1'b1;
    end
    step();
    chk("rnd_busy", {63'd0, busy_o}, {63'd0, m_cap});
    chk("rnd_ready", {63'd0, rd_ready_o}, {63'd0, !m_cap});
    chk("rnd_valid", {63'd0, rd_data_valid_o}, {63'd0, e_valid});
    chk("rnd_data", {32'd0, rd_data_o}, {32'd0, e_data});
    chk("rnd_err", {63'd0, rd_err_o}, {63'd0, e_err});
  endtask

  initial begin
    for (int k = 0; k < 6; k++) cnt[k] = 64'd0;
    cnt[5] = 64'h0000_0001_8000_0002;

    vecs[0]  = mk(0, 1, 4'd12, 64'd5, 1, 32'd0, 0, 0);
    vecs[1]  = mk(0, 1, 4'd13, 64'd5, 1, {30'd0, DELTA, 1'b0}, 0, 0);
    vecs[2]  = mk(0, 1, 4'd14, 64'd5, 1, 32'd0, 1, 0);
    vecs[3]  = mk(0, 1, 4'd10, 64'd5, 1, 32'd0, 0, 0);
    vecs[4]  = mk(1, 0, 4'd0,  64'd5, 0, 32'd0, 0, 1);
    vecs[5]  = mk(0, 1, 4'd0,  64'd5, 0, 32'd0, 0, 0);
    vecs[6]  = mk(0, 1, 4'd10, 64'd5, 1, 32'h8000_0002, 0, 0);
    vecs[7]  = mk(0, 1, 4'd11, 64'd5, 1, 32'h0000_0001, 0, 0);
    vecs[8]  = mk(0, 1, 4'd12, 64'd5, 1, 32'd1, 0, 0);
    vecs[9]  = mk(0, 1, 4'd13, 64'd5, 1, {30'd0, DELTA, 1'b1}, 0, 0);
    vecs[10] = mk(1, 1, 4'd0,  64'd9, 1, 32'd5, 0, 1);
    vecs[11] = mk(0, 1, 4'd0,  64'd9, 0, 32'd0, 0, 0);
    vecs[12] = mk(0, 1, 4'd0,  64'd9, 1, DELTA ? 32'd4 : 32'd9, 0, 0);
    vecs[13] = mk(0, 1, 4'd1,  64'd9, 1, 32'd0, 0, 0);
    vecs[14] = mk(0, 0, 4'd12, 64'd9, 0, 32'd0, 0, 0);
    vecs[15] = mk(0, 1, 4'd15, 64'd9, 1, 32'd0, 1, 0);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      snap_i = vecs[i].snap; rd_valid_i = vecs[i].rv; rd_addr_i = vecs[i].addr;
      cnt[0] = vecs[i].c0;
      step();
      chk($sformatf("v%0d_valid", i), {63'd0, rd_data_valid_o}, {63'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_data", i), {32'd0, rd_data_o}, {32'd0, vecs[i].e_data});
      chk($sformatf("v%0d_err", i), {63'd0, rd_err_o}, {63'd0, vecs[i].e_err});
      chk($sformatf("v%0d_busy", i), {63'd0, busy_o}, {63'd0, vecs[i].e_busy});
      chk($sformatf("v%0d_ready", i), {63'd0, rd_ready_o}, {63'd0, !vecs[i].e_busy});
    end

    // snap held three cycles: captures in cycles 2 and 4 only, snap_id 2 -> 4
    rd_valid_i = 1'b0; snap_i = 1'b1;
    step(); chk("hold_busy1", {63'd0, busy_o}, 64'd1);
    step(); chk("hold_busy2", {63'd0, busy_o}, 64'd0);
    step(); chk("hold_busy3", {63'd0, busy_o}, 64'd1);
    snap_i = 1'b0;
    step(); chk("hold_busy4", {63'd0, busy_o}, 64'd0);
    rd_valid_i = 1'b1; rd_addr_i = 4'd12;
    step(); chk("hold_id", {32'd0, rd_data_o}, 64'd4);
    rd_addr_i = 4'd14;
    step();
    chk("idx14_err", {63'd0, rd_err_o}, 64'd1);
    chk("idx14_data", {32'd0, rd_data_o}, 64'd0);

    // reset in the middle of a capture, with a read response pending
    snap_i = 1'b1; rd_addr_i = 4'd12;
    step(); chk("abort_busy", {63'd0, busy_o}, 64'd1);
    chk("abort_pend", {63'd0, rd_data_valid_o}, 64'd1);
    snap_i = 1'b0; rd_valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    chk("abort_busy_drop", {63'd0, busy_o}, 64'd0);
    chk("abort_valid_drop", {63'd0, rd_data_valid_o}, 64'd0);
    step(); rst_i = 1'b1;
    step(); chk("abort_no_pulse", {63'd0, rd_data_valid_o}, 64'd0);
    chk("abort_not_busy", {63'd0, busy_o}, 64'd0);
    rd_valid_i = 1'b1; rd_addr_i = 4'd12;
    step(); chk("abort_id", {32'd0, rd_data_o}, 64'd0);
    chk("abort_id_valid", {63'd0, rd_data_valid_o}, 64'd1);
    rd_valid_i = 1'b0;

`ifdef PROF_DELTA_MODE_EN
    do_reset();
    cnt[0] = 64'd100; snap_i = 1'b1; step(); snap_i = 1'b0; step();
    rd_valid_i = 1'b1; rd_addr_i = 4'd0; step(); rd_valid_i = 1'b0;
    chk("delta_first", {32'd0, rd_data_o}, 64'd100);
    cnt[0] = 64'd250; snap_i = 1'b1; step(); snap_i = 1'b0; step();
    rd_valid_i = 1'b1; step(); rd_valid_i = 1'b0;
    chk("delta_second", {32'd0, rd_data_o}, 64'd150);
    cnt[0] = 64'hFFFF_FFFF_FFFF_FFF0; snap_i = 1'b1; step(); snap_i = 1'b0; step();
    cnt[0] = 64'h10; snap_i = 1'b1; step(); snap_i = 1'b0; step();
    rd_valid_i = 1'b1; step();
    chk("delta_wrap_lo", {32'd0, rd_data_o}, 64'h20);
    rd_addr_i = 4'd1; step(); rd_valid_i = 1'b0;
    chk("delta_wrap_hi", {32'd0, rd_data_o}, 64'd0);
`endif

    do_reset();
    for (int i = 0; i < 400; i++) rand_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prof_snapshot_reader.md
PROF_SNAPSHOT_READER -- requirements
Module: prof_snapshot_reader

Interface
REQ-001 Parameter CNT_BITS, default 64: width of each profiling counter input; SHALL be 64.
REQ-002 Parameter XLEN, default 32: read-data bus width; SHALL be 32.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous assert, active-low.
REQ-005 iflush_cnt_i, iflush_ltc_i, dflush_rd_cnt_i, dflush_rd_ltc_i, dflush_wb_cnt_i, dflush_wb_ltc_i  input  CNT_BITS each  live cache-profiler counters, indexed 0..5 in this order.
REQ-006 snap_i  input  1  single-cycle snapshot request.
REQ-007 busy_o  output  1  high while a capture is in progress.
REQ-008 rd_valid_i  input  1  read request valid.
REQ-009 rd_addr_i  input  4  word index of the requested read.
REQ-010 rd_ready_o  output  1  read request may be accepted this cycle.
REQ-011 rd_data_o  output  XLEN  read data.
REQ-012 rd_data_valid_o  output  1  rd_data_o valid, one-cycle pulse.
REQ-013 rd_err_o  output  1  read targeted an unmapped index; qualified by rd_data_valid_o.

Function
REQ-014 FSM states: S_Idle (no snapshot held), S_Capture (latching), S_Ready (snapshot held).
REQ-015 snap_i in S_Idle or S_Ready -> S_Capture next cycle; S_Capture -> S_Ready unconditionally after exactly one cycle.
REQ-016 In S_Capture: all six inputs latched into snapshot registers in the same cycle, snap_id (32 bit) incremented, modulo 2^32 wrap.
REQ-017 busy_o = 1 only in S_Capture; rd_ready_o = 0 in S_Capture, 1 otherwise.
REQ-018 snap_i asserted during S_Capture is ignored; no second capture, no extra snap_id increment.
REQ-019 Read accepted when rd_valid_i & rd_ready_o; response on the next cycle: rd_data_valid_o = 1 for exactly one cycle, rd_data_o/rd_err_o valid in that cycle.
REQ-020 Word map: index 2k = snapshot k bits [31:0], index 2k+1 = snapshot k bits [63:32], k = 0..5; index 12 = snap_id; index 13 = {30'b0, in_delta_mode, snapshot_held}.
REQ-021 Indices 14, 15: rd_data_o = 0, rd_err_o = 1; all other indices rd_err_o = 0.
REQ-022 Read in S_Idle returns 0 for indices 0..11, with rd_err_o = 0.
REQ-023 snap_i and an accepted read in the same cycle: read returns pre-capture snapshot values; capture starts next cycle.
REQ-024 Reads never alter snapshot contents; the two halves of one counter come from the same capture whenever no snap_i falls between the two reads.
REQ-025 rd_data_o = 0 and rd_err_o = 0 whenever rd_data_valid_o = 0.

Reset
REQ-026 On rst_i low: state S_Idle, snapshot registers, baselines and snap_id = 0, busy_o = 0, rd_data_valid_o = 0, rd_data_o = 0, rd_err_o = 0; rd_ready_o = 1 once reset releases.
REQ-027 Reset during S_Capture or with a read response pending aborts it; no rd_data_valid_o pulse after release.

Configuration
REQ-028 Macro PROF_DELTA_MODE_EN: when defined, each capture stores (counter − baseline_k) modulo 2^CNT_BITS and then sets baseline_k <= counter; baselines are 0 after reset; index 13 bit 1 reads 1.
REQ-029 Without PROF_DELTA_MODE_EN: each capture stores raw counter values, no baseline registers exist, and index 13 bit 1 reads 0.

Verification
REQ-030 Reset, read index 12 with no snapshot -> rd_data_o = 0, rd_err_o = 0, rd_data_valid_o one cycle after acceptance.
REQ-031 Set dflush_wb_ltc_i = 0x0000_0001_8000_0002, pulse snap_i, read indices 10 and 11 -> 0x8000_0002, 0x0000_0001; busy_o high for exactly one cycle.
REQ-032 snap_i plus a read of index 0 in the same cycle, with iflush_cnt changed from 5 (held) to 9 (live) -> read returns 5; next read of index 0 after capture returns 9.
REQ-033 snap_i held high for 3 cycles -> snap_id increments by 2 (captures in cycles 2 and 4); rd_addr_i = 14 -> rd_err_o = 1, rd_data_o = 0.
REQ-034 PROF_DELTA_MODE_EN: iflush_cnt 100 at first snap, 250 at second -> index 0 reads 100, then 150; baseline 0xFFFF_FFFF_FFFF_FFF0 with live 0x10 -> index 0 reads 0x20.
REQ-035 Assert rst_i low during S_Capture -> busy_o drops immediately, snap_id = 0, no rd_data_valid_o pulse after release.
